// File: rtl/decoder_38_arbiter_pkg.sv
// Shared constants and state encoding for the decoder_38 front-end arbiter.
package decoder_38_pkg;

    localparam logic [2:0] DEC_EN_ON  = 3'b100;
    localparam logic [2:0] DEC_EN_OFF = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/decoder_38_arbiter_if.sv
// Requester/decoder-side bundle of the arbiter: requests and codes in, decoder pins and status out.
interface decoder_38_arbiter_if
    import decoder_38_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] code;
    logic [2:0]        dec_enable;
    logic [2:0]        dec_switch;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   ack;
    logic              busy;

    modport master (
        output req, code,
        input  dec_enable, dec_switch, grant, ack, busy
    );

    modport slave (
        input  req, code,
        output dec_enable, dec_switch, grant, ack, busy
    );
endinterface

// File: rtl/decoder_38_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping mod NREQ.
module rr_pick
    import decoder_38_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_req
);
    localparam int SW = IDX_W + 1;

    logic [SW-1:0] sum;

    // Scan the search order backwards so the last hit is the first candidate after rr_ptr.
    always_comb begin
        sum     = '0;
        win_idx = '0;
        any_req = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            if (req[sum[IDX_W-1:0]]) begin
                win_idx = sum[IDX_W-1:0];
            end
        end
        onehot = any_req ? (NREQ'(1) << win_idx) : '0;
    end
endmodule

// File: rtl/decoder_38_arbiter.sv
// Round-robin arbiter that time-shares one decoder_38 (and its LEDs) between NREQ requesters.
module decoder_38_arbiter
    import decoder_38_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    decoder_38_arbiter_if.slave bus
);
    localparam int               IDX_W     = $clog2(NREQ);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [CNT_W-1:0] counter;

    logic [NREQ-1:0]  pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;
    logic [2:0]       code_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_code
        assign code_arr[i] = bus.code[3*i +: 3];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .onehot  (pick_onehot),
        .win_idx (pick_idx),
        .any_req (any_req)
    );

    // Completion and early release share one exit; only completion earns an ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            win_idx        <= '0;
            counter        <= '0;
            bus.dec_enable <= DEC_EN_OFF;
            bus.dec_switch <= 3'b000;
            bus.grant      <= '0;
            bus.ack        <= '0;
            bus.busy       <= 1'b0;
        end else begin
            bus.ack <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.dec_switch <= code_arr[pick_idx];
                        bus.grant      <= pick_onehot;
                        bus.dec_enable <= DEC_EN_ON;
                        bus.busy       <= 1'b1;
                        win_idx        <= pick_idx;
                        counter        <= '0;
                        state          <= HOLD;
                    end
                end
                HOLD: begin
                    if (counter == HOLD_LAST || !bus.req[win_idx]) begin
                        if (counter == HOLD_LAST) begin
                            bus.ack <= bus.grant;
                        end
                        bus.grant      <= '0;
                        bus.dec_enable <= DEC_EN_OFF;
                        rr_ptr         <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                        counter        <= '0;
                        if (GAP_CYCLES == 0) begin
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                GAP: begin
                    if (counter == GAP_LAST) begin
                        bus.busy <= 1'b0;
                        counter  <= '0;
                        state    <= IDLE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_decoder_38_arbiter.sv
// Directed bench for decoder_38_arbiter with NREQ=4, HOLD_CYCLES=16, GAP_CYCLES=2.
module tb_decoder_38_arbiter;
    import decoder_38_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   failures;

    decoder_38_arbiter_if #(.NREQ(4)) bus ();

    decoder_38_arbiter #(
        .NREQ        (4),
        .HOLD_CYCLES (16),
        .GAP_CYCLES  (2),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] r, input logic [11:0] c);
        bus.req  = r;
        bus.code = c;
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] en, input logic [2:0] sw,
                               input logic [3:0] gr, input logic [3:0] ak, input logic bz);
        tests++;
        assert (bus.dec_enable === en) else begin
            failures++;
            $error("[TB] FAIL %s dec_enable observed=%b expected=%b", tag, bus.dec_enable, en);
        end
        tests++;
        assert (bus.dec_switch === sw) else begin
            failures++;
            $error("[TB] FAIL %s dec_switch observed=%b expected=%b", tag, bus.dec_switch, sw);
        end
        tests++;
        assert (bus.grant === gr) else begin
            failures++;
            $error("[TB] FAIL %s grant observed=%b expected=%b", tag, bus.grant, gr);
        end
        tests++;
        assert (bus.ack === ak) else begin
            failures++;
            $error("[TB] FAIL %s ack observed=%b expected=%b", tag, bus.ack, ak);
        end
        tests++;
        assert (bus.busy === bz) else begin
            failures++;
            $error("[TB] FAIL %s busy observed=%b expected=%b", tag, bus.busy, bz);
        end
    endtask

    // n displayed cycles of requester idx showing code sw.
    task automatic holdCycles(input string tag, input int n, input int idx, input logic [2:0] sw);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checkOutput(tag, DEC_EN_ON, sw, 4'b0001 << idx, 4'b0000, 1'b1);
        end
    endtask

    // Exit cycle, second gap cycle, then the idle arbitration cycle.
    task automatic gapTail(input string tag, input logic [3:0] ack_exp, input logic [2:0] sw);
        @(negedge clk);
        checkOutput({tag, "_exit"}, DEC_EN_OFF, sw, 4'b0000, ack_exp, 1'b1);
        @(negedge clk);
        checkOutput({tag, "_gap2"}, DEC_EN_OFF, sw, 4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        checkOutput({tag, "_idle"}, DEC_EN_OFF, sw, 4'b0000, 4'b0000, 1'b0);
    endtask

    task automatic fullGrant(input string tag, input int idx, input logic [2:0] sw);
        holdCycles(tag, 16, idx, sw);
        gapTail(tag, 4'b0001 << idx, sw);
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(4'b0000, 12'h000);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", DEC_EN_OFF, 3'b000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_noreq", DEC_EN_OFF, 3'b000, 4'b0000, 4'b0000, 1'b0);
        end

        applyStimulus(4'b0001, 12'b000_000_000_010);
        fullGrant("single0", 0, 3'b010);
        applyStimulus(4'b0000, 12'b000_000_000_010);

        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset2", DEC_EN_OFF, 3'b000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;

        applyStimulus(4'b1111, 12'b111_100_010_000);
        fullGrant("rr_g0", 0, 3'b000);
        fullGrant("rr_g1", 1, 3'b010);
        fullGrant("rr_g2", 2, 3'b100);
        fullGrant("rr_g3", 3, 3'b111);
        fullGrant("rr_wrap0", 0, 3'b000);
        fullGrant("rr_g1b", 1, 3'b010);
        fullGrant("rr_g2b", 2, 3'b100);

        applyStimulus(4'b0101, 12'b111_100_010_000);
        fullGrant("skip_to0", 0, 3'b000);

        applyStimulus(4'b0010, 12'b111_100_010_000);
        holdCycles("early1", 5, 1, 3'b010);
        applyStimulus(4'b0000, 12'b111_100_010_000);
        gapTail("early1", 4'b0000, 3'b010);

        applyStimulus(4'b1111, 12'b111_100_010_000);
        fullGrant("after_early2", 2, 3'b100);

        holdCycles("abort3", 8, 3, 3'b111);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_reset", DEC_EN_OFF, 3'b000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
        holdCycles("restart0", 3, 0, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/decoder_38_arbiter.md
Name: decoder_38_arbiter

Overview:
Round-robin arbiter that shares one decoder_38 instance, and its LED bank, between NREQ requesters. Each requester presents a 3-bit code. The winner's code is latched and driven onto the decoder's switch input with the decoder enabled for HOLD_CYCLES cycles. The decoder is then blanked for GAP_CYCLES cycles before the next grant. The block sits directly in front of decoder_38 and drives its enable/switch pins; decoder_38 keeps its own clk/rst.

Parameters:
NREQ, 4, number of requesters (2..8)
HOLD_CYCLES, 16, cycles a granted code is displayed (>=1)
GAP_CYCLES, 2, blank cycles after each grant (0 = no gap)
CNT_W, 8, hold/gap counter width; must hold max(HOLD_CYCLES, GAP_CYCLES)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
req  in  NREQ  request per requester, level
code  in  3*NREQ  code for requester i in bits [3i+2:3i]
dec_enable  out  3  to decoder_38 enable: 3'b100 = on, 3'b000 = off
dec_switch  out  3  to decoder_38 switch: latched code of current winner
grant  out  NREQ  one-hot grant, all zero when no grant
ack  out  NREQ  one-cycle pulse to the winner on normal completion
busy  out  1  high in HOLD and GAP

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, rr_ptr=0, counter=0.
  - dec_enable=3'b000, dec_switch=3'b000, grant=0, ack=0, busy=0.
  - Applies mid-operation as well; no ack is issued for an aborted grant.
- All outputs are registered.
- States: IDLE, HOLD, GAP.
- IDLE:
  - If req!=0, the winner is the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... wrapping mod NREQ.
  - At the same edge: latch code[winner] into dec_switch, set grant[winner]=1, dec_enable=3'b100, busy=1, counter=0, go to HOLD.
  - Latency: req sampled at edge k gives outputs valid after edge k.
  - If req=0: outputs stay idle values; dec_switch holds its last value.
- HOLD:
  - Counter increments each cycle. The grant is visible for exactly HOLD_CYCLES cycles.
  - On the edge ending cycle HOLD_CYCLES: ack[winner]=1 for one cycle, grant=0, dec_enable=3'b000, rr_ptr=(winner+1) mod NREQ.
  - Next state is GAP, or IDLE if GAP_CYCLES=0.
- Early release: if req[winner] is low at any HOLD edge before completion:
  - Same exit as completion (grant=0, dec_enable off, rr_ptr advance), but no ack.
  - Next state is GAP, or IDLE if GAP_CYCLES=0.
- Code changes during HOLD are ignored; the latched value holds.
- Other requesters' req changes are ignored until arbitration.
- GAP:
  - busy=1, dec_enable=3'b000 for exactly GAP_CYCLES cycles, then IDLE.
  - A request pending at the end of GAP is arbitrated at the first IDLE edge.
- Back-to-back: with all req high, minimum period per grant is 1+HOLD_CYCLES+GAP_CYCLES cycles, including one IDLE arbitration cycle.
- rr_ptr wraps NREQ-1 -> 0.
- Counter compare: counter==HOLD_CYCLES-1 (resp. GAP_CYCLES-1). No overflow is possible given the CNT_W constraint.
- ack and grant are never high in the same cycle.
- Exactly one grant bit or none is ever high.

Decomposition:
- Shared package decoder_38_pkg: DEC_EN_ON=3'b100, DEC_EN_OFF=3'b000, state encoding (IDLE=2'd0, HOLD=2'd1, GAP=2'd2).
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req, rr_ptr.
  - Outputs: onehot winner, winner index, any_req.
- The top holds the FSM, counter, latches and pointer.

Test Plan:
- Reset then req=0 for 20 cycles -> dec_enable=000, grant=0, ack=0, busy=0 throughout.
- req=4'b0001, code0=3'b010 held -> 1 cycle after sampling, grant=0001 and dec_enable=100, dec_switch=010 (decoder led=8'b11111011) for 16 cycles. Then ack=0001 for 1 cycle, then 2 cycles with dec_enable=000.
- req=4'b1111, codes {3'b111,3'b100,3'b010,3'b000} (code3..code0) -> grants in order 0,1,2,3,0, one every 19 cycles. dec_switch sequence is 000,010,100,111.
- After requester 2 is served (rr_ptr=3), assert req=4'b0101 -> grant goes to 0 (wrap), not 2.
- Requester 1 granted, drop req[1] after 5 HOLD cycles -> grant clears at that edge, no ack, GAP 2 cycles, rr_ptr=2.
- rst_n low for one edge at HOLD cycle 8 -> next cycle all outputs at reset values, no ack. With req still high, the grant restarts from rr_ptr=0.
